regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (a3/wd3/we) between two writeback

---
 rtl/regfile_wb_arbiter_if.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
//   hold               freeze writeback
//   req0_* / req1_*    valid/ready writeback requests (ALU, LSU)
//   claim_*            issue-stage destination reservation
//   rf_*               register file write port (a3/wd3/we)
//   busy               pending-write scoreboard
//   rs1/rs2, fwd_*     in-flight write forwarding compare
// Modports: slave = arbiter side, master = pipeline/bench side.
interface regfile_wb_arbiter_if #(
  parameter int NREG = 32,
  parameter int XLEN = 32
);
  logic            hold;
  logic            req0_valid;
  logic [4:0]      req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [4:0]      req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;
  logic            claim_valid;
  logic [4:0]      claim_rd;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic            rf_we;
  logic [NREG-1:0] busy;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd_data;

  modport slave (
    input  hold, req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
           claim_valid, claim_rd, rs1, rs2,
    output req0_ready, req1_ready, rf_a3, rf_wd3, rf_we, busy,
           fwd1_hit, fwd2_hit, fwd_data
  );

  modport master (
    output hold, req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
           claim_valid, claim_rd, rs1, rs2,
    input  req0_ready, req1_ready, rf_a3, rf_wd3, rf_we, busy,
           fwd1_hit, fwd2_hit, fwd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two writeback
// requesters (req0 = ALU/branch-link, req1 = LSU) with round-robin
// arbitration, and keeps a pending-write scoreboard for RAW stalls.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   wb     regfile_wb_arbiter_if.slave (requests, claims, rf write port,
//          busy bitmap, forwarding compare)
// Optional feature: define WB_FORWARD_EN to drive fwd1_hit/fwd2_hit/fwd_data
// from the write in flight; otherwise those outputs are tied to 0.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb
);

  logic            last_grant;   // requester index that won the last accept
  logic            gnt_any;
  logic            gnt1;         // 1 = req1 granted, 0 = req0 granted
  logic            acc;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic [NREG-1:0] busy_q, busy_d;

  // Round-robin: on contention, the requester that did not win last time.
  always_comb begin
    gnt_any = wb.req0_valid || wb.req1_valid;
    gnt1    = 1'b0;
    if (wb.req0_valid && wb.req1_valid) gnt1 = (last_grant == 1'b0);
    else if (wb.req1_valid)             gnt1 = 1'b1;
  end

  assign wb.req0_ready = !wb.hold && gnt_any && !gnt1;
  assign wb.req1_ready = !wb.hold && gnt_any &&  gnt1;

  assign acc      = !wb.hold && gnt_any;
  assign acc_rd   = gnt1 ? wb.req1_rd   : wb.req0_rd;
  assign acc_data = gnt1 ? wb.req1_data : wb.req0_data;

  // Claim is applied after the clear so a same-cycle claim on the same rd wins.
  always_comb begin
    busy_d = busy_q;
    if (acc && acc_rd != 5'd0)                busy_d[acc_rd]      = 1'b0;
    if (wb.claim_valid && wb.claim_rd != 5'd0) busy_d[wb.claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb.rf_a3   <= '0;
      wb.rf_wd3  <= '0;
      wb.rf_we   <= 1'b0;
      busy_q     <= '0;
      last_grant <= 1'b1;
    end else begin
      // x0 writes are acked but never reach the register file.
      wb.rf_we <= acc && (acc_rd != 5'd0);
      busy_q   <= busy_d;
      if (acc) begin
        wb.rf_a3   <= acc_rd;
        wb.rf_wd3  <= acc_data;
        last_grant <= gnt1;
      end
    end
  end

  assign wb.busy = busy_q;

`ifdef WB_FORWARD_EN
  // Bridges the cycle before the write is visible through the read ports.
  assign wb.fwd1_hit = wb.rf_we && (wb.rf_a3 == wb.rs1) && (wb.rs1 != 5'd0);
  assign wb.fwd2_hit = wb.rf_we && (wb.rf_a3 == wb.rs2) && (wb.rs2 != 5'd0);
  assign wb.fwd_data = wb.rf_wd3;
`else
  assign wb.fwd1_hit = 1'b0;
  assign wb.fwd2_hit = 1'b0;
  assign wb.fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREG(32), .XLEN(32)) wb();
  regfile_wb_arbiter #(.NREG(32), .XLEN(32)) dut (.clk(clk), .reset(reset), .wb(wb));

  int errs = 0;
  int checks = 0;

  // Model: who won last, the write the register file sees this cycle, busy set.
  int          m_last;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_busy [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check against the model at negedge, then advance the model.
  task automatic step();
    bit e0, e1;
    logic [4:0]  rd;
    logic [31:0] dat, bv;
    @(negedge clk);
    e0 = 0; e1 = 0;
    if (!wb.hold) begin
      if (wb.req0_valid && wb.req1_valid) begin
        if (m_last == 0) e1 = 1; else e0 = 1;
      end else if (wb.req0_valid) e0 = 1;
      else if (wb.req1_valid) e1 = 1;
    end
    if (!reset) begin
      check("req0_ready", {31'd0, wb.req0_ready}, {31'd0, e0});
      check("req1_ready", {31'd0, wb.req1_ready}, {31'd0, e1});
    end
    check("rf_we", {31'd0, wb.rf_we}, {31'd0, m_we});
    if (m_we) begin
      check("rf_a3", {27'd0, wb.rf_a3}, {27'd0, m_a3});
      check("rf_wd3", wb.rf_wd3, m_wd);
    end
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    check("busy", wb.busy, bv);
`ifdef WB_FORWARD_EN
    check("fwd1_hit", {31'd0, wb.fwd1_hit}, {31'd0, m_we && m_a3 == wb.rs1 && wb.rs1 != 0});
    check("fwd2_hit", {31'd0, wb.fwd2_hit}, {31'd0, m_we && m_a3 == wb.rs2 && wb.rs2 != 0});
    if (m_we) check("fwd_data", wb.fwd_data, m_wd);
`else
    check("fwd1_hit", {31'd0, wb.fwd1_hit}, 32'd0);
    check("fwd2_hit", {31'd0, wb.fwd2_hit}, 32'd0);
    check("fwd_data", wb.fwd_data, 32'd0);
`endif
    @(posedge clk);
    if (reset) begin
      m_we = 0; m_a3 = 0; m_wd = 0; m_last = 1;
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      m_we = 0;
      if (e0 || e1) begin
        rd  = e1 ? wb.req1_rd : wb.req0_rd;
        dat = e1 ? wb.req1_data : wb.req0_data;
        m_we = (rd != 0);
        m_a3 = rd;
        m_wd = dat;
        m_last = e1 ? 1 : 0;
        if (rd != 0) m_busy[rd] = 0;
      end
      if (wb.claim_valid && wb.claim_rd != 0) m_busy[wb.claim_rd] = 1;
    end
    #1;
    // Requesters drop valid once accepted; a reset drops everything pending.
    if (reset || e0) wb.req0_valid = 0;
    if (reset || e1) wb.req1_valid = 0;
  endtask

  task automatic req0(input logic [4:0] rd, input logic [31:0] d);
    wb.req0_valid = 1; wb.req0_rd = rd; wb.req0_data = d;
  endtask

  task automatic req1(input logic [4:0] rd, input logic [31:0] d);
    wb.req1_valid = 1; wb.req1_rd = rd; wb.req1_data = d;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  initial begin
    reset = 1;
    wb.hold = 0; wb.req0_valid = 0; wb.req0_rd = 0; wb.req0_data = 0;
    wb.req1_valid = 0; wb.req1_rd = 0; wb.req1_data = 0;
    wb.claim_valid = 0; wb.claim_rd = 0; wb.rs1 = 0; wb.rs2 = 0;
    m_last = 1; m_we = 0; m_a3 = 0; m_wd = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;

    // 1: reset values, then first write and its latency
    @(posedge clk); #1;
    do_reset();
    check("rst_we", {31'd0, wb.rf_we}, 32'd0);
    check("rst_busy", wb.busy, 32'd0);
    check("rst_a3", {27'd0, wb.rf_a3}, 32'd0);
    check("rst_wd3", wb.rf_wd3, 32'd0);
    req0(5'd5, 32'h11);
    step();
    step();

    // 2: contention after reset -> req0 then req1
    do_reset();
    req0(5'd1, 32'hA); req1(5'd2, 32'hB);
    step();
    req0(5'd1, 32'hA);
    step();
    step();
    step();

    // 3: x0 write acked but dropped
    req1(5'd0, 32'hFFFF_FFFF);
    step();
    step();

    // 4: scoreboard claim / same-cycle claim vs. clear / clear
    wb.claim_valid = 1; wb.claim_rd = 5'd7;
    step();
    req0(5'd7, 32'h77);
    step();
    wb.claim_valid = 0;
    req0(5'd7, 32'h78);
    step();
    step();
    wb.claim_valid = 1; wb.claim_rd = 5'd0;  // x0 claim ignored
    step();
    wb.claim_valid = 0;

    // 5: hold for 3 cycles with both valid, then accept followed by reset
    wb.hold = 1; req0(5'd9, 32'h99); req1(5'd10, 32'h100);
    step(); step(); step();
    wb.hold = 0;
    wb.claim_valid = 1; wb.claim_rd = 5'd12;
    step();
    wb.claim_valid = 0;
    reset = 1;
    step();
    reset = 0;
    step();

    // 6: forwarding of the write in flight
    req0(5'd3, 32'h55);
    step();
    wb.rs1 = 5'd3; wb.rs2 = 5'd4;
    step();
    wb.rs1 = 0; wb.rs2 = 0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (!wb.req0_valid && $urandom_range(1, 0) == 1) req0(5'($urandom), $urandom);
      if (!wb.req1_valid && $urandom_range(1, 0) == 1) req1(5'($urandom), $urandom);
      wb.claim_valid = ($urandom_range(2, 0) == 0);
      wb.claim_rd    = 5'($urandom);
      wb.hold        = ($urandom_range(7, 0) == 0);
      reset          = ($urandom_range(59, 0) == 0);
      wb.rs1 = ($urandom_range(1, 0) == 1) ? m_a3 : 5'($urandom);
      wb.rs2 = ($urandom_range(1, 0) == 1) ? m_a3 : 5'($urandom);
      step();
    end
    reset = 0; wb.hold = 0; wb.claim_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
